// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - two-requester round-robin arbiter for a simple dual-port BRAM (optional RAW_BYPASS_EN)
module bram_rr_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester A
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    // requester B
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    // BRAM side
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // candidate qualification; reset blocks every grant
    logic a_wc, b_wc, a_rc, b_rc;
    logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;

    // priority pointers: 0 = A preferred, 1 = B preferred
    logic wr_pri_q, wr_pri_d;
    logic rd_pri_q, rd_pri_d;

    // read tags: which requester owns the BRAM data returning next cycle
    logic rd_tag_a_q, rd_tag_a_d;
    logic rd_tag_b_q, rd_tag_b_d;

    // shared read data selected for the returning requester
    logic [DATA_WIDTH-1:0] rd_data;

    // Candidate and grant decode for both independent arbiters
    always_comb begin
        a_wc = !rst && a_req &&  a_wr;
        b_wc = !rst && b_req &&  b_wr;
        a_rc = !rst && a_req && !a_wr;
        b_rc = !rst && b_req && !b_wr;

        // a lone candidate always wins; on a tie the pointer decides
        wr_gnt_a = a_wc && (!b_wc || !wr_pri_q);
        wr_gnt_b = b_wc && (!a_wc ||  wr_pri_q);
        rd_gnt_a = a_rc && (!b_rc || !rd_pri_q);
        rd_gnt_b = b_rc && (!a_rc ||  rd_pri_q);

        // a requester carries one request, so at most one of its grants is set
        a_gnt = wr_gnt_a || rd_gnt_a;
        b_gnt = wr_gnt_b || rd_gnt_b;
    end

    // Write datapath: steer the winner's address and data, zero when idle
    always_comb begin
        mem_wen   = wr_gnt_a || wr_gnt_b;
        mem_waddr = '0;
        mem_wdata = '0;
        if (wr_gnt_a) begin
            mem_waddr = a_addr;
            mem_wdata = a_wdata;
        end else if (wr_gnt_b) begin
            mem_waddr = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Read address: winner's address, zero when no read is granted
    always_comb begin
        mem_raddr = '0;
        if (rd_gnt_a) begin
            mem_raddr = a_addr;
        end else if (rd_gnt_b) begin
            mem_raddr = b_addr;
        end
    end

    // Next-state for priority pointers and read tags
    always_comb begin
        wr_pri_d = wr_pri_q;
        rd_pri_d = rd_pri_q;
        // the granted side hands priority to the other side; no grant, no change
        if (wr_gnt_a) begin
            wr_pri_d = 1'b1;
        end else if (wr_gnt_b) begin
            wr_pri_d = 1'b0;
        end
        if (rd_gnt_a) begin
            rd_pri_d = 1'b1;
        end else if (rd_gnt_b) begin
            rd_pri_d = 1'b0;
        end
        rd_tag_a_d = rd_gnt_a;
        rd_tag_b_d = rd_gnt_b;
    end

    // Priority and tag state; reset discards any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pri_q   <= 1'b0;
            rd_pri_q   <= 1'b0;
            rd_tag_a_q <= 1'b0;
            rd_tag_b_q <= 1'b0;
        end else begin
            wr_pri_q   <= wr_pri_d;
            rd_pri_q   <= rd_pri_d;
            rd_tag_a_q <= rd_tag_a_d;
            rd_tag_b_q <= rd_tag_b_d;
        end
    end

`ifdef RAW_BYPASS_EN
    // same-cycle write/read collision capture for read-after-write forwarding
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

    // Detect a granted write and read to the same address
    always_comb begin
        hit_d      = mem_wen && (rd_gnt_a || rd_gnt_b) && (mem_waddr == mem_raddr);
        byp_data_d = mem_wdata;
    end

    // Hold the collision flag and the forwarded write data for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q      <= hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Returned data: new write value on a collision, otherwise the BRAM word
    always_comb begin
        rd_data = hit_q ? byp_data_q : mem_rdata;
    end
`else
    // Returned data: the BRAM word as read (old value on a collision)
    always_comb begin
        rd_data = mem_rdata;
    end
`endif

    // Response routing: only the tagged requester sees data, others see zero
    always_comb begin
        a_rvalid = rd_tag_a_q;
        b_rvalid = rd_tag_b_q;
        a_rdata  = rd_tag_a_q ? rd_data : '0;
        b_rdata  = rd_tag_b_q ? rd_data : '0;
    end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb/tb_bram_rr_arbiter.sv - scoreboard testbench for bram_rr_arbiter
module tb_bram_rr_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    bram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // environment BRAM: registered read, read-first on collisions
    logic [DW-1:0] bram [0:255];
    always @(posedge clk) begin
        if (mem_wen) bram[mem_waddr] <= mem_wdata;
        mem_rdata <= bram[mem_raddr];
    end

    // reference model state
    logic [DW-1:0] ref_mem [0:255];
    bit            m_wr_pri, m_rd_pri;
    bit            seen_a_gnt, seen_b_gnt;

    typedef struct {
        int            cyc;
        bit            who;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc_n);
        end
    endtask

    // called at negedge: check responses, check grants/datapath, advance model
    task automatic sample();
        bit            ea, eb, awc, bwc, arc, brc, ewa, ewb, era, erb;
        logic [DW-1:0] ed, ewd, erd;
        logic [AW-1:0] ewad, erad;
        exp_t          e;
        cyc_n++;
        ea = 0; eb = 0; ed = '0;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n - 1) begin
            e  = exp_q.pop_front();
            ea = !e.who;
            eb = e.who;
            ed = e.data;
        end
        check_val("a_rvalid", {31'd0, a_rvalid}, {31'd0, ea});
        check_val("b_rvalid", {31'd0, b_rvalid}, {31'd0, eb});
        check_val("a_rdata", a_rdata, ea ? ed : '0);
        check_val("b_rdata", b_rdata, eb ? ed : '0);

        awc = !rst && a_req && a_wr;   bwc = !rst && b_req && b_wr;
        arc = !rst && a_req && !a_wr;  brc = !rst && b_req && !b_wr;
        if (awc && bwc) begin ewa = !m_wr_pri; ewb = m_wr_pri; end
        else begin ewa = awc; ewb = bwc; end
        if (arc && brc) begin era = !m_rd_pri; erb = m_rd_pri; end
        else begin era = arc; erb = brc; end
        ewad = ewa ? a_addr : (ewb ? b_addr : '0);
        ewd  = ewa ? a_wdata : (ewb ? b_wdata : '0);
        erad = era ? a_addr : (erb ? b_addr : '0);

        check_val("a_gnt", {31'd0, a_gnt}, {31'd0, (ewa || era)});
        check_val("b_gnt", {31'd0, b_gnt}, {31'd0, (ewb || erb)});
        check_val("mem_wen", {31'd0, mem_wen}, {31'd0, (ewa || ewb)});
        check_val("mem_waddr", {24'd0, mem_waddr}, {24'd0, ewad});
        check_val("mem_wdata", mem_wdata, ewd);
        check_val("mem_raddr", {24'd0, mem_raddr}, {24'd0, erad});

        if (rst) begin
            m_wr_pri = 0;
            m_rd_pri = 0;
        end else begin
            if (era || erb) begin
                erd = ref_mem[erad];
`ifdef RAW_BYPASS_EN
                if ((ewa || ewb) && ewad == erad) erd = ewd;
`endif
                e.cyc = cyc_n; e.who = erb; e.data = erd;
                exp_q.push_back(e);
                m_rd_pri = era;
            end
            if (ewa || ewb) begin
                ref_mem[ewad] = ewd;
                m_wr_pri = ewa;
            end
        end
        seen_a_gnt = a_gnt;
        seen_b_gnt = b_gnt;
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_req = req; a_wr = wr; a_addr = addr; a_wdata = d;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        b_req = req; b_wr = wr; b_addr = addr; b_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        // reset state, with a request pending to show gnt is forced low
        cyc();
        drive_a(1, 1, 8'h01, 32'h1);
        cyc();
        rst = 1'b0;

        // 1: reset mid-read, after moving both pointers away from A
        drive_a(1, 1, 8'h02, 32'hAAAA0002);
        cyc();
        drive_a(1, 0, 8'h02, 32'h0);
        cyc();
        drive_a(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check_val("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        check_val("rst_a_rdata", a_rdata, 32'd0);
        exp_q.delete();
        drive_a(1, 0, 8'h02, 32'h0);
        #1;
        check_val("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        cyc();
        rst = 1'b0;
        drive_a(0, 0, 0, 0);
        cyc();
        // read pointer back at A: tied reads go to A first
        drive_a(1, 0, 8'h02, 32'h0);
        drive_b(1, 0, 8'h03, 32'h0);
        #1;
        check_val("rd_pri_reset", {30'd0, a_gnt, b_gnt}, 32'd2);
        cyc();
        drive_a(0, 0, 0, 0);
        cyc();
        drive_b(0, 0, 0, 0);
        cyc();

        // 2: continuous contention on writes, alternation starts at A
        for (int i = 0; i < 6; i++) begin
            drive_a(1, 1, 8'h10, 32'hA0000000 + i);
            drive_b(1, 1, 8'h20, 32'hB0000000 + i);
            #1;
            check_val("alt_wen", {31'd0, mem_wen}, 32'd1);
            check_val("alt_gnt", {30'd0, a_gnt, b_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            cyc();
        end
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        cyc();

        // 3: write and read in the same cycle, different addresses
        drive_a(1, 1, 8'h05, 32'hDEADBEEF);
        drive_b(1, 0, 8'h07, 32'h0);
        cyc();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        cyc();

        // 4: same-address collision
        drive_a(1, 1, 8'h33, 32'h11111111);
        cyc();
        drive_a(1, 1, 8'h33, 32'h22222222);
        drive_b(1, 0, 8'h33, 32'h0);
        cyc();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        #1;
`ifdef RAW_BYPASS_EN
        check_val("raw_b_rdata", b_rdata, 32'h22222222);
`else
        check_val("raw_b_rdata", b_rdata, 32'h11111111);
`endif
        cyc();

        // 5: B alone reads three times, then both read and A wins
        drive_b(1, 0, 8'h05, 32'h0);
        cyc();
        drive_b(1, 0, 8'h20, 32'h0);
        cyc();
        drive_b(1, 0, 8'h33, 32'h0);
        cyc();
        drive_a(1, 0, 8'h10, 32'h0);
        drive_b(1, 0, 8'h05, 32'h0);
        cyc();
        drive_a(0, 0, 0, 0);

        // 6: B holds priority and wins, A keeps its request and is served next
        drive_a(1, 0, 8'h33, 32'h0);
        cyc();
        drive_b(0, 0, 0, 0);
        #1;
        check_val("held_a_gnt", {31'd0, a_gnt}, 32'd1);
        check_val("held_a_raddr", {24'd0, mem_raddr}, 32'h33);
        cyc();
        drive_a(0, 0, 0, 0);
        cyc();

        // random traffic, requests held until granted
        for (int i = 0; i < 60; i++) begin
            if (!a_req || seen_a_gnt)
                drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
            if (!b_req || seen_b_gnt)
                drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        cyc();
        cyc();
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
